hsv_mask_bbox: RTL and testbench

Downstream consumer of the rgb2hsv stage. It takes the per-pixel H/S/V stream and its Valid strobe and thresholds each pixel into a binary colour mask. It tracks raster position and accumulates, per frame, the matched-pixel count and the bounding box of matched pixels. At end of frame it publishes the results with a one-cycle Done pulse.

---
 rtl/hsv_mask_bbox_pkg.sv | 33 +++
 rtl/hsv_mask_bbox_threshold.sv | 22 ++
 rtl/hsv_mask_bbox.sv | 184 ++++++++++++++++++
 tb/tb_hsv_mask_bbox.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_mask_bbox_pkg.sv
// Shared widths, ranges and threshold types for the HSV colour-mask and
// bounding-box stage that follows rgb2hsv.
package hsv_mask_bbox_pkg;

    localparam int HEIGHT  = 400;
    localparam int WIDTH   = 400;
    localparam int XW      = $clog2(WIDTH);
    localparam int YW      = $clog2(HEIGHT);
    localparam int CW      = $clog2(WIDTH * HEIGHT + 1);

    localparam int HW      = 9;
    localparam int SVW     = 7;
    localparam int HUE_MAX = 359;
    localparam int SV_MAX  = 100;

    typedef struct packed {
        logic [HW-1:0]  h_lo;
        logic [HW-1:0]  h_hi;
        logic [SVW-1:0] s_min;
        logic [SVW-1:0] v_min;
    } thresh_t;

    // A window with lo > hi wraps through 0 (the red hues near 359/0).
    function automatic logic hue_in_window(input logic [HW-1:0] h,
                                           input logic [HW-1:0] lo,
                                           input logic [HW-1:0] hi);
        if (lo <= hi) begin
            return (h >= lo) && (h <= hi);
        end
        return (h >= lo) || (h <= hi);
    endfunction

endpackage

// File: rtl/hsv_mask_bbox_threshold.sv
// Purely combinational HSV window test for one pixel.
// Kept separate so later multi-colour masks can instantiate several.
module hsv_threshold
    import hsv_mask_bbox_pkg::*;
(
    input  logic [HW-1:0]  h,
    input  logic [SVW-1:0] s,
    input  logic [SVW-1:0] v,
    input  logic [HW-1:0]  h_lo,
    input  logic [HW-1:0]  h_hi,
    input  logic [SVW-1:0] s_min,
    input  logic [SVW-1:0] v_min,
    output logic           match
);

    // A pixel matches when its hue is in the (possibly wrapping) window and
    // both saturation and value reach their minimums.
    always_comb begin
        match = hue_in_window(h, h_lo, h_hi) && (s >= s_min) && (v >= v_min);
    end

endmodule

// File: rtl/hsv_mask_bbox.sv
// Thresholds the H/S/V pixel stream into a binary mask, tracks raster
// position and publishes per-frame matched-pixel count and bounding box.
module hsv_mask_bbox
    import hsv_mask_bbox_pkg::*;
#(
    parameter int height = HEIGHT,
    parameter int width  = WIDTH,
    parameter int XW     = $clog2(width),
    parameter int YW     = $clog2(height),
    parameter int CW     = $clog2(width * height + 1)
)(
    input  logic           CLK,
    input  logic           Reset_0,
    input  logic           Valid,
    input  logic [HW-1:0]  H,
    input  logic [SVW-1:0] S,
    input  logic [SVW-1:0] V,
    input  logic [HW-1:0]  H_lo,
    input  logic [HW-1:0]  H_hi,
    input  logic [SVW-1:0] S_min,
    input  logic [SVW-1:0] V_min,
    output logic           Mask,
    output logic           Mask_valid,
    output logic [XW-1:0]  X_min,
    output logic [XW-1:0]  X_max,
    output logic [YW-1:0]  Y_min,
    output logic [YW-1:0]  Y_max,
    output logic [CW-1:0]  Count,
    output logic           Found,
    output logic           Done
);

    localparam logic [XW-1:0] X_LAST = XW'(width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(height - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    thresh_t shadow;
    thresh_t thr_use;

    logic at_first;
    logic frame_end;
    logic match;

    logic [CW-1:0] cnt,    cnt_nxt;
    logic [XW-1:0] bx_min, bx_min_nxt;
    logic [XW-1:0] bx_max, bx_max_nxt;
    logic [YW-1:0] by_min, by_min_nxt;
    logic [YW-1:0] by_max, by_max_nxt;
    logic          hit,    hit_nxt;

    assign at_first  = (x == '0) && (y == '0);
    assign frame_end = Valid && (x == X_LAST) && (y == Y_LAST);

    // Pixel (0,0) sees the live threshold inputs; every other pixel uses the
    // values captured at the start of the frame.
    always_comb begin
        thr_use = shadow;
        if (at_first) begin
            thr_use.h_lo  = H_lo;
            thr_use.h_hi  = H_hi;
            thr_use.s_min = S_min;
            thr_use.v_min = V_min;
        end
    end

    hsv_threshold u_threshold (
        .h     (H),
        .s     (S),
        .v     (V),
        .h_lo  (thr_use.h_lo),
        .h_hi  (thr_use.h_hi),
        .s_min (thr_use.s_min),
        .v_min (thr_use.v_min),
        .match (match)
    );

    // Accumulator values including the current pixel, so the last pixel of a
    // frame can be published on the same edge it is counted.
    always_comb begin
        cnt_nxt    = cnt;
        bx_min_nxt = bx_min;
        bx_max_nxt = bx_max;
        by_min_nxt = by_min;
        by_max_nxt = by_max;
        hit_nxt    = hit;
        if (Valid) begin
            if (at_first) begin
                hit_nxt    = match;
                cnt_nxt    = match ? CW'(1) : '0;
                bx_min_nxt = '0;
                bx_max_nxt = '0;
                by_min_nxt = '0;
                by_max_nxt = '0;
            end else if (match) begin
                cnt_nxt = cnt + CW'(1);
                if (!hit) begin
                    hit_nxt    = 1'b1;
                    bx_min_nxt = x;
                    bx_max_nxt = x;
                    by_min_nxt = y;
                    by_max_nxt = y;
                end else begin
                    if (x < bx_min) bx_min_nxt = x;
                    if (x > bx_max) bx_max_nxt = x;
                    if (y < by_min) by_min_nxt = y;
                    if (y > by_max) by_max_nxt = y;
                end
            end
        end
    end

    // Raster position, threshold shadow, accumulators and mask register.
    always_ff @(posedge CLK) begin
        if (!Reset_0) begin
            x          <= '0;
            y          <= '0;
            shadow     <= '0;
            cnt        <= '0;
            bx_min     <= '0;
            bx_max     <= '0;
            by_min     <= '0;
            by_max     <= '0;
            hit        <= 1'b0;
            Mask       <= 1'b0;
            Mask_valid <= 1'b0;
        end else begin
            Mask_valid <= Valid;
            if (Valid) begin
                Mask   <= match;
                cnt    <= cnt_nxt;
                bx_min <= bx_min_nxt;
                bx_max <= bx_max_nxt;
                by_min <= by_min_nxt;
                by_max <= by_max_nxt;
                hit    <= hit_nxt;
                if (at_first) begin
                    shadow <= thr_use;
                end
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Result registers change only at frame end and hold until the next one,
    // so re-initialising the accumulators for the next frame cannot disturb them.
    always_ff @(posedge CLK) begin
        if (!Reset_0) begin
            X_min <= '0;
            X_max <= '0;
            Y_min <= '0;
            Y_max <= '0;
            Count <= '0;
            Found <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (frame_end) begin
                Done  <= 1'b1;
                Found <= hit_nxt;
                if (hit_nxt) begin
                    Count <= cnt_nxt;
                    X_min <= bx_min_nxt;
                    X_max <= bx_max_nxt;
                    Y_min <= by_min_nxt;
                    Y_max <= by_max_nxt;
                end else begin
                    Count <= '0;
                    X_min <= '0;
                    X_max <= '0;
                    Y_min <= '0;
                    Y_max <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hsv_mask_bbox.sv
// Directed self-checking bench for hsv_mask_bbox on a small 8x6 frame.
module tb_hsv_mask_bbox;

    localparam int WD = 8;
    localparam int HT = 6;
    localparam int N  = WD * HT;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int CW = 6;

    logic          CLK = 1'b0;
    logic          Reset_0;
    logic          Valid;
    logic [8:0]    H, H_lo, H_hi;
    logic [6:0]    S, V, S_min, V_min;
    logic          Mask, Mask_valid, Found, Done;
    logic [XW-1:0] X_min, X_max;
    logic [YW-1:0] Y_min, Y_max;
    logic [CW-1:0] Count;

    int total = 0;
    int bad   = 0;

    int h_arr [N];
    int s_arr [N];
    int v_arr [N];
    bit m_arr [N];

    logic [8:0] nh_lo, nh_hi;
    logic [6:0] ns_min, nv_min;

    always #5 CLK = ~CLK;

    hsv_mask_bbox #(.height(HT), .width(WD), .XW(XW), .YW(YW), .CW(CW)) dut (
        .CLK        (CLK),
        .Reset_0    (Reset_0),
        .Valid      (Valid),
        .H          (H),
        .S          (S),
        .V          (V),
        .H_lo       (H_lo),
        .H_hi       (H_hi),
        .S_min      (S_min),
        .V_min      (V_min),
        .Mask       (Mask),
        .Mask_valid (Mask_valid),
        .X_min      (X_min),
        .X_max      (X_max),
        .Y_min      (Y_min),
        .Y_max      (Y_max),
        .Count      (Count),
        .Found      (Found),
        .Done       (Done)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic fill(input int h, input int s, input int v, input bit m);
        for (int i = 0; i < N; i++) begin
            h_arr[i] = h; s_arr[i] = s; v_arr[i] = v; m_arr[i] = m;
        end
    endtask

    task automatic set_thr(input int lo, input int hi, input int smin, input int vmin);
        H_lo = 9'(lo); H_hi = 9'(hi); S_min = 7'(smin); V_min = 7'(vmin);
    endtask

    // Streams pixels start..N-1, checking Mask/Mask_valid/Done every cycle.
    task automatic play_frame(input bit gaps, input int chg_idx, input int start);
        bit want_done;
        for (int i = start; i < N; i++) begin
            if (i == chg_idx) begin
                H_lo = nh_lo; H_hi = nh_hi; S_min = ns_min; V_min = nv_min;
            end
            Valid = 1'b1;
            H = 9'(h_arr[i]); S = 7'(s_arr[i]); V = 7'(v_arr[i]);
            @(posedge CLK); #1;
            Valid = 1'b0;
            want_done = (i == N - 1);
            total++;
            if (Mask_valid !== 1'b1 || Mask !== m_arr[i]) begin
                bad++;
                $display("[TB] FAIL mask px%0d: got valid=%b mask=%b want valid=1 mask=%b",
                         i, Mask_valid, Mask, m_arr[i]);
            end
            total++;
            if (Done !== want_done) begin
                bad++;
                $display("[TB] FAIL done px%0d: got %b want %b", i, Done, want_done);
            end
            if (gaps) begin
                H = 9'd0; S = 7'd0; V = 7'd0;
                @(posedge CLK); #1;
                total++;
                if (Mask_valid !== 1'b0 || Mask !== m_arr[i] || Done !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL gap px%0d: got valid=%b mask=%b done=%b want 0 %b 0",
                             i, Mask_valid, Mask, Done, m_arr[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset_0 = 1'b0; Valid = 1'b0;
        H = '0; S = '0; V = '0;
        set_thr(0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({Mask, Mask_valid, Found, Done} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset flags: got %b want 0000", {Mask, Mask_valid, Found, Done});
        end
        total++;
        if ({Count, X_min, X_max, Y_min, Y_max} !== '0) begin
            bad++;
            $display("[TB] FAIL reset results: got cnt=%0d box=%0d,%0d,%0d,%0d want all 0",
                     Count, X_min, X_max, Y_min, Y_max);
        end
        Reset_0 = 1'b1;
        @(posedge CLK); #1;
        total++;
        if ({Mask_valid, Done, Count} !== '0) begin
            bad++;
            $display("[TB] FAIL reset idle: got valid=%b done=%b cnt=%0d want 0", Mask_valid, Done, Count);
        end
    endtask

    task automatic test_uniform();
        set_thr(100, 140, 50, 50);
        fill(120, 80, 80, 1'b1);
        play_frame(1'b0, -1, 0);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== {1'b1, 6'd48, 3'd0, 3'd7, 3'd0, 3'd5}) begin
            bad++;
            $display("[TB] FAIL uniform: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 48 0,7,0,5",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
    endtask

    task automatic test_single();
        set_thr(100, 140, 50, 50);
        fill(0, 0, 0, 1'b0);
        h_arr[29] = 120; s_arr[29] = 80; v_arr[29] = 80; m_arr[29] = 1'b1;
        play_frame(1'b0, -1, 0);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== {1'b1, 6'd1, 3'd5, 3'd5, 3'd3, 3'd3}) begin
            bad++;
            $display("[TB] FAIL single: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 1 5,5,3,3",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
    endtask

    task automatic test_wrap();
        set_thr(340, 20, 80, 80);
        fill(180, 80, 80, 1'b0);
        h_arr[0] = 350; m_arr[0] = 1'b1;
        h_arr[1] = 10;  m_arr[1] = 1'b1;
        h_arr[3] = 340; m_arr[3] = 1'b1;
        h_arr[4] = 20;  m_arr[4] = 1'b1;
        h_arr[5] = 21;
        h_arr[6] = 339;
        h_arr[7] = 350; s_arr[7] = 79;
        h_arr[8] = 10;  v_arr[8] = 79;
        play_frame(1'b0, -1, 0);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== {1'b1, 6'd4, 3'd0, 3'd4, 3'd0, 3'd0}) begin
            bad++;
            $display("[TB] FAIL wrap: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 4 0,4,0,0",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
    endtask

    task automatic test_none();
        set_thr(100, 140, 50, 50);
        fill(0, 0, 0, 1'b0);
        play_frame(1'b0, -1, 0);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== '0) begin
            bad++;
            $display("[TB] FAIL none: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want all 0",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
    endtask

    task automatic test_midframe();
        set_thr(100, 140, 50, 50);
        nh_lo = 9'd200; nh_hi = 9'd220; ns_min = 7'd50; nv_min = 7'd50;
        fill(120, 80, 80, 1'b1);
        play_frame(1'b0, 20, 0);
        total++;
        if ({Found, Count} !== {1'b1, 6'd48}) begin
            bad++;
            $display("[TB] FAIL midframe cur: got found=%b cnt=%0d want 1 48", Found, Count);
        end
        fill(120, 80, 80, 1'b0);
        play_frame(1'b0, -1, 0);
        total++;
        if ({Found, Count} !== {1'b0, 6'd0}) begin
            bad++;
            $display("[TB] FAIL midframe next: got found=%b cnt=%0d want 0 0", Found, Count);
        end
    endtask

    task automatic test_gaps();
        set_thr(100, 140, 50, 50);
        fill(0, 0, 0, 1'b0);
        h_arr[29] = 120; s_arr[29] = 80; v_arr[29] = 80; m_arr[29] = 1'b1;
        play_frame(1'b1, -1, 0);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== {1'b1, 6'd1, 3'd5, 3'd5, 3'd3, 3'd3}) begin
            bad++;
            $display("[TB] FAIL gaps: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 1 5,5,3,3",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
    endtask

    task automatic test_back_to_back();
        set_thr(100, 140, 50, 50);
        fill(0, 0, 0, 1'b0);
        h_arr[N-1] = 120; s_arr[N-1] = 80; v_arr[N-1] = 80; m_arr[N-1] = 1'b1;
        play_frame(1'b0, -1, 0);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== {1'b1, 6'd1, 3'd7, 3'd7, 3'd5, 3'd5}) begin
            bad++;
            $display("[TB] FAIL b2b frameA: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 1 7,7,5,5",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
        fill(0, 0, 0, 1'b0);
        h_arr[0] = 120; s_arr[0] = 80; v_arr[0] = 80; m_arr[0] = 1'b1;
        Valid = 1'b1; H = 9'd120; S = 7'd80; V = 7'd80;
        @(posedge CLK); #1;
        Valid = 1'b0;
        total++;
        if ({Mask, Done, Found, Count, X_min, X_max, Y_min, Y_max} !==
            {1'b1, 1'b0, 1'b1, 6'd1, 3'd7, 3'd7, 3'd5, 3'd5}) begin
            bad++;
            $display("[TB] FAIL b2b hold: got mask=%b done=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 0 1 7,7,5,5",
                     Mask, Done, Count, X_min, X_max, Y_min, Y_max);
        end
        play_frame(1'b0, -1, 1);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== {1'b1, 6'd1, 3'd0, 3'd0, 3'd0, 3'd0}) begin
            bad++;
            $display("[TB] FAIL b2b frameB: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 1 0,0,0,0",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
    endtask

    task automatic test_reset_mid();
        set_thr(100, 140, 50, 50);
        for (int i = 0; i < 20; i++) begin
            Valid = 1'b1; H = 9'd120; S = 7'd80; V = 7'd80;
            @(posedge CLK); #1;
        end
        Valid = 1'b0; Reset_0 = 1'b0;
        @(posedge CLK); #1;
        Reset_0 = 1'b1;
        total++;
        if ({Mask, Mask_valid, Found, Done, Count, X_min, X_max, Y_min, Y_max} !== '0) begin
            bad++;
            $display("[TB] FAIL reset mid: got mask=%b mv=%b found=%b done=%b cnt=%0d box=%0d,%0d,%0d,%0d want all 0",
                     Mask, Mask_valid, Found, Done, Count, X_min, X_max, Y_min, Y_max);
        end
        fill(0, 0, 0, 1'b0);
        h_arr[10] = 120; s_arr[10] = 80; v_arr[10] = 80; m_arr[10] = 1'b1;
        play_frame(1'b0, -1, 0);
        total++;
        if ({Found, Count, X_min, X_max, Y_min, Y_max} !== {1'b1, 6'd1, 3'd2, 3'd2, 3'd1, 3'd1}) begin
            bad++;
            $display("[TB] FAIL reset mid frame: got found=%b cnt=%0d box=%0d,%0d,%0d,%0d want 1 1 2,2,1,1",
                     Found, Count, X_min, X_max, Y_min, Y_max);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_single();
        test_wrap();
        test_none();
        test_midframe();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
